// File: rtl/fifo16_drain_pkg.sv
// fifo16_pkg: shared constants for the fifo16 read-side drain controller.
//   - state encoding of the control FSM (values are visible on the state port)
//   - default data/address widths and the derived FIFO depth
package fifo16_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int BUF_WIDTH_DEF  = 4;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    function automatic int fifo_depth(input int buf_width);
        return 1 << buf_width;
    endfunction

    localparam int FIFO_DEPTH = fifo_depth(BUF_WIDTH_DEF);

endpackage

// File: rtl/fifo16_drain_if.sv
// fifo16_drain_if: bundles the fifo16 read port and the downstream stream.
//   fifo_empty/fifo_counter/fifo_data : fifo16 status and registered buf_out
//   fifo_rd_en                        : read strobe back to fifo16
//   data_out/valid_out/ready_in       : valid/ready stream to the next stage
// Modports: slave = the drain controller, master = the FIFO + sink side.
interface fifo16_drain_if
    import fifo16_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_WIDTH  = BUF_WIDTH_DEF
);
    logic                  fifo_empty;
    logic [BUF_WIDTH:0]    fifo_counter;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_in;

    modport slave (
        input  fifo_empty, fifo_counter, fifo_data, ready_in,
        output fifo_rd_en, data_out, valid_out
    );

    modport master (
        output fifo_empty, fifo_counter, fifo_data, ready_in,
        input  fifo_rd_en, data_out, valid_out
    );
endinterface

// File: rtl/fifo16_drain_skid.sv
// fifo16_skid: 2-entry register buffer holding words read from fifo16.
//   clk, rst   : clock, async active-low reset
//   push_i     : append din_i at the tail
//   pop_i      : drop the head (caller only pops when count_o != 0)
//   head_o     : oldest entry, count_o : number of valid entries (0..2)
// A push and pop in the same cycle keeps the count and preserves order.
module fifo16_skid #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] ent0_q, ent1_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    // a push into a full buffer is dropped; the read issue logic never asks for one
                    if (cnt_q == 2'd0) begin
                        ent0_q <= din_i;
                        cnt_q  <= 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        ent1_q <= din_i;
                        cnt_q  <= 2'd2;
                    end
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_q <= din_i;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_o  = ent0_q;
    assign count_o = cnt_q;
endmodule

// File: rtl/fifo16_drain.sv
// fifo16_drain: read-side controller directly downstream of fifo16.
//   clk, rst                 : clock, async active-low reset
//   init                     : request threshold reload (IDLE -> INIT)
//   umbral_alto/umbral_bajo  : pause assert/release thresholds, latched in INIT
//   bus (slave)              : fifo16 read port + valid/ready output stream
//   pause                    : registered hysteresis back-pressure to the writer
//   error_out                : sticky occupancy error
//   state                    : current FSM state encoding
// fifo16 has one cycle of read latency, so each read is tracked by an
// in-flight flag and captured into the skid buffer on the following edge.
module fifo16_drain
    import fifo16_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_WIDTH  = BUF_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [BUF_WIDTH:0] umbral_alto,
    input  logic [BUF_WIDTH:0] umbral_bajo,
    fifo16_drain_if.slave      bus,
    output logic               pause,
    output logic               error_out,
    output logic [2:0]         state
);
    localparam logic [BUF_WIDTH:0] DEPTH = (BUF_WIDTH+1)'(fifo_depth(BUF_WIDTH));

    state_e             state_q;
    logic [BUF_WIDTH:0] alto_q, bajo_q;
    logic               inflight_q;
    logic               pause_q, error_q;

    logic [DATA_WIDTH-1:0] head;
    logic [1:0]            skid_cnt;
    logic [1:0]            occ;
    logic                  pop, rd_en, drained, err_cond, pause_hyst;

    fifo16_skid #(.W(DATA_WIDTH)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .din_i   (bus.fifo_data),
        .head_o  (head),
        .count_o (skid_cnt)
    );

    assign bus.valid_out = (skid_cnt != 2'd0) && (state_q != ST_ERROR);
    assign bus.data_out  = head;
    assign pop           = bus.valid_out && bus.ready_in;

    // Slots already committed: held words plus the word in flight, minus
    // the word leaving this cycle. Keeping it below 2 means the skid can
    // never overflow, while still allowing one read per clk when streaming.
    assign occ   = skid_cnt + {1'b0, inflight_q} - {1'b0, pop};
    assign rd_en = (state_q == ST_ACTIVE) && !bus.fifo_empty && (occ < 2'd2);
    assign bus.fifo_rd_en = rd_en;

    assign drained  = bus.fifo_empty && (skid_cnt == 2'd0) && !inflight_q;
    assign err_cond = (bus.fifo_counter > DEPTH) ||
                      ((state_q == ST_IDLE) && (bajo_q > alto_q));

    always_comb begin
        pause_hyst = pause_q;
        if (bus.fifo_counter >= alto_q)
            pause_hyst = 1'b1;
        else if (bus.fifo_counter <= bajo_q)
            pause_hyst = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RESET;
            alto_q     <= '0;
            bajo_q     <= '0;
            inflight_q <= 1'b0;
            pause_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            if (state_q == ST_RESET) begin
                state_q <= ST_INIT;
                pause_q <= 1'b0;
            end else if (state_q == ST_ERROR || err_cond) begin
                // sticky until reset
                state_q <= ST_ERROR;
                pause_q <= 1'b1;
                error_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        alto_q  <= umbral_alto;
                        bajo_q  <= umbral_bajo;
                        pause_q <= 1'b0;
                        if (!init)
                            state_q <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (init) begin
                            state_q <= ST_INIT;
                            pause_q <= 1'b0;
                        end else begin
                            pause_q <= pause_hyst;
                            if (!bus.fifo_empty || skid_cnt != 2'd0)
                                state_q <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        // a pending init waits until everything has drained
                        if (drained && init) begin
                            state_q <= ST_INIT;
                            pause_q <= 1'b0;
                        end else begin
                            pause_q <= pause_hyst;
                            if (drained)
                                state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_ERROR;
                endcase
            end
        end
    end

    assign pause     = pause_q;
    assign error_out = error_q;
    assign state     = state_q;
endmodule

// File: tb/tb_fifo16_drain.sv
module tb_fifo16_drain;
    localparam int DW = 4;
    localparam int BW = 4;

    logic          clk = 1'b1;
    logic          rst = 1'b0;
    logic          init = 1'b0;
    logic [BW:0]   ua = '0, ub = '0;
    logic          pause, error_out;
    logic [2:0]    state;
    int            n_vec = 0, n_err = 0;

    fifo16_drain_if #(.DATA_WIDTH(DW), .BUF_WIDTH(BW)) bus();

    fifo16_drain #(.DATA_WIDTH(DW), .BUF_WIDTH(BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .init        (init),
        .umbral_alto (ua),
        .umbral_bajo (ub),
        .bus         (bus),
        .pause       (pause),
        .error_out   (error_out),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Behavioural fifo16: depth 16, registered buf_out, 1-cycle read latency.
    logic [DW-1:0] mem [16];
    logic [3:0]    wp, rp;
    logic [BW:0]   cnt;
    logic [DW-1:0] buf_q;
    logic          push_en = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          force_en = 1'b0;
    logic [BW:0]   force_val = '0;
    logic          do_wr, do_rd;

    assign do_wr = push_en && (cnt < 5'd16);
    assign do_rd = bus.fifo_rd_en && (cnt != 5'd0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0; rp <= '0; cnt <= '0; buf_q <= '0;
        end else begin
            if (do_wr) begin mem[wp] <= push_data; wp <= wp + 4'd1; end
            if (do_rd) begin buf_q <= mem[rp]; rp <= rp + 4'd1; end
            cnt <= cnt + {4'd0, do_wr} - {4'd0, do_rd};
        end
    end

    assign bus.fifo_empty   = (cnt == 5'd0);
    assign bus.fifo_counter = force_en ? force_val : cnt;
    assign bus.fifo_data    = buf_q;

    // words accepted by the sink, sampled just before the accepting edge
    logic [DW-1:0] got [$];
    always @(negedge clk) begin
        #3;
        if (rst && bus.valid_out && bus.ready_in) got.push_back(bus.data_out);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.ready_in = 1'b0;
        #12;
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_vec++; if ({bus.fifo_rd_en, bus.valid_out, bus.data_out, pause, error_out} !== 8'h00) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 00", {bus.fifo_rd_en, bus.valid_out, bus.data_out, pause, error_out});
        end
        #3;
        rst = 1'b1; init = 1'b1; ua = 5'd12; ub = 5'd4;
        @(posedge clk);
        tick();
        n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL init_state1: got %0d expected 1", state); end
        tick();
        n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL init_state2: got %0d expected 1", state); end
        init = 1'b0;
        tick();
        n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL idle_state: got %0d expected 2", state); end
        n_vec++; if ({bus.fifo_rd_en, bus.valid_out, bus.data_out, pause, error_out} !== 8'h00) begin
            n_err++; $display("FAIL idle_outputs: got %h expected 00", {bus.fifo_rd_en, bus.valid_out, bus.data_out, pause, error_out});
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] vals [5];
        int act_i = -1, v_first = -1, v_last = -1, v_cnt = 0;
        vals = '{4'd1, 4'd2, 4'd10, 4'd2, 4'd3};
        got.delete();
        bus.ready_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (act_i < 0 && state == 3'd3) act_i = i;
            if (bus.valid_out) begin
                if (v_first < 0) v_first = i;
                v_last = i; v_cnt++;
            end
            push_en   = (i < 5);
            push_data = (i < 5) ? vals[i] : '0;
            tick();
        end
        // ACTIVE is entered one edge after fifo_empty falls; then read edge, capture edge
        n_vec++; if (v_first - act_i != 2) begin n_err++; $display("FAIL stream_latency: got %0d expected 2", v_first - act_i); end
        n_vec++; if (v_cnt != 5 || v_last - v_first != 4) begin
            n_err++; $display("FAIL stream_rate: got %0d words over %0d clk expected 5 over 5", v_cnt, v_last - v_first + 1);
        end
        n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL stream_idle: got %0d expected 2", state); end
        n_vec++; if (got.size() != 5) begin n_err++; $display("FAIL stream_count: got %0d expected 5", got.size()); end
        else for (int k = 0; k < 5; k++) begin
            n_vec++; if (got[k] !== vals[k]) begin n_err++; $display("FAIL stream_word%0d: got %0d expected %0d", k, got[k], vals[k]); end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] w [6];
        int rd_pulses = 0;
        bit done = 0;
        w = '{4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd6};
        got.delete();
        bus.ready_in = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (bus.fifo_rd_en) rd_pulses++;
            if (i >= 6) begin
                n_vec++; if (bus.fifo_counter !== 5'd4) begin n_err++; $display("FAIL stall_counter: got %0d expected 4", bus.fifo_counter); end
                n_vec++; if (bus.data_out !== w[0] || bus.valid_out !== 1'b1) begin
                    n_err++; $display("FAIL stall_hold: got %0d/v%0b expected %0d/v1", bus.data_out, bus.valid_out, w[0]);
                end
            end
            push_en   = (i < 6);
            push_data = (i < 6) ? w[i] : '0;
            tick();
        end
        n_vec++; if (rd_pulses != 2) begin n_err++; $display("FAIL stall_reads: got %0d expected 2", rd_pulses); end
        bus.ready_in = 1'b1;
        for (int j = 0; j < 30 && !done; j++) begin
            tick();
            if (state == 3'd2 && got.size() >= 6) done = 1;
        end
        n_vec++; if (!done) begin n_err++; $display("FAIL stall_drain: got %0d words expected 6 (timeout)", got.size()); end
        n_vec++; if (got.size() != 6) begin n_err++; $display("FAIL stall_count: got %0d expected 6", got.size()); end
        else for (int k = 0; k < 6; k++) begin
            n_vec++; if (got[k] !== w[k]) begin n_err++; $display("FAIL stall_word%0d: got %0d expected %0d", k, got[k], w[k]); end
        end
    endtask

    task automatic test_pause();
        logic [DW-1:0] w [16];
        int n = 0;
        bit seen4 = 0, done = 0, hit = 0;
        got.delete();
        bus.ready_in = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (bus.fifo_counter == 5'd12) hit = 1;
            else begin
                w[n] = DW'((n * 5 + 1) % 16);
                push_en = 1'b1; push_data = w[n]; n++;
                tick();
            end
        end
        push_en = 1'b0;
        n_vec++; if (!hit) begin n_err++; $display("FAIL pause_fill: got counter %0d expected 12 (timeout)", bus.fifo_counter); end
        n_vec++; if (pause !== 1'b0) begin n_err++; $display("FAIL pause_before: got %0b expected 0", pause); end
        tick();
        n_vec++; if (pause !== 1'b1 || bus.fifo_counter !== 5'd12) begin
            n_err++; $display("FAIL pause_set: got %0b at counter %0d expected 1 at 12", pause, bus.fifo_counter);
        end
        bus.ready_in = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (seen4) begin
                n_vec++; if (pause !== 1'b0) begin n_err++; $display("FAIL pause_release: got %0b expected 0", pause); end
                done = 1;
            end else if (bus.fifo_counter == 5'd5) begin
                n_vec++; if (pause !== 1'b1) begin n_err++; $display("FAIL pause_hold5: got %0b expected 1", pause); end
            end else if (bus.fifo_counter == 5'd4) begin
                n_vec++; if (pause !== 1'b1) begin n_err++; $display("FAIL pause_hold4: got %0b expected 1", pause); end
                seen4 = 1;
            end
        end
        n_vec++; if (!done) begin n_err++; $display("FAIL pause_timeout: got counter %0d expected to pass 4", bus.fifo_counter); end
        done = 0;
        for (int j = 0; j < 30 && !done; j++) begin
            tick();
            if (state == 3'd2 && got.size() >= n) done = 1;
        end
        n_vec++; if (got.size() != n || n != 14) begin n_err++; $display("FAIL pause_count: got %0d/%0d expected 14", got.size(), n); end
        else for (int k = 0; k < 14; k++) begin
            n_vec++; if (got[k] !== w[k]) begin n_err++; $display("FAIL pause_word%0d: got %0d expected %0d", k, got[k], w[k]); end
        end
    endtask

    task automatic test_simul();
        logic [3:0] pat;
        int rd_seen = 0;
        bit done = 0;
        pat = 4'b1101;
        got.delete();
        for (int i = 0; i < 40 && !done; i++) begin
            push_en      = (i < 5);
            push_data    = DW'(5 + i);
            bus.ready_in = (i < 7) ? 1'b0 : pat[i % 4];
            #1;
            if (bus.fifo_rd_en) rd_seen++;
            if (i > 10 && state == 3'd2 && got.size() >= 5) done = 1;
            else tick();
        end
        push_en = 1'b0;
        bus.ready_in = 1'b1;
        n_vec++; if (!done) begin n_err++; $display("FAIL simul_drain: got %0d words expected 5 (timeout)", got.size()); end
        n_vec++; if (rd_seen != 5) begin n_err++; $display("FAIL simul_reads: got %0d expected 5", rd_seen); end
        n_vec++; if (got.size() != 5) begin n_err++; $display("FAIL simul_count: got %0d expected 5", got.size()); end
        else for (int k = 0; k < 5; k++) begin
            n_vec++; if (got[k] !== DW'(5 + k)) begin n_err++; $display("FAIL simul_word%0d: got %0d expected %0d", k, got[k], 5 + k); end
        end
        tick();
    endtask

    task automatic test_midreset();
        bus.ready_in = 1'b1;
        for (int i = 0; i < 10 && !bus.valid_out; i++) begin
            push_en = 1'b1; push_data = DW'(i + 7);
            tick();
        end
        n_vec++; if (bus.valid_out !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got valid %0b expected 1", bus.valid_out); end
        rst = 1'b0; push_en = 1'b0;
        #1;
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL midrst_state: got %0d expected 0", state); end
        n_vec++; if ({bus.fifo_rd_en, bus.valid_out, bus.data_out, pause, error_out} !== 8'h00) begin
            n_err++; $display("FAIL midrst_outputs: got %h expected 00", {bus.fifo_rd_en, bus.valid_out, bus.data_out, pause, error_out});
        end
        tick();
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL midrst_idle: got %0d expected 2", state); end
        got.delete();
    endtask

    task automatic test_error();
        force_en = 1'b1; force_val = 5'd16;
        tick();
        n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL err_depth16: got %0d expected 2", state); end
        force_val = 5'd17;
        tick();
        n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL err_state: got %0d expected 4", state); end
        n_vec++; if ({error_out, pause, bus.fifo_rd_en, bus.valid_out} !== 4'b1100) begin
            n_err++; $display("FAIL err_outputs: got %b expected 1100", {error_out, pause, bus.fifo_rd_en, bus.valid_out});
        end
        force_en = 1'b0; push_en = 1'b1; push_data = 4'd9;
        tick();
        push_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (state !== 3'd4 || bus.fifo_rd_en !== 1'b0 || error_out !== 1'b1) begin
                n_err++; $display("FAIL err_sticky%0d: got st%0d rd%0b e%0b expected st4 rd0 e1", i, state, bus.fifo_rd_en, error_out);
            end
        end
        // inverted thresholds are flagged once in IDLE
        rst = 1'b0;
        tick();
        rst = 1'b1; init = 1'b1; ua = 5'd3; ub = 5'd6;
        tick();
        tick();
        init = 1'b0;
        tick();
        n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL thr_idle: got %0d expected 2", state); end
        tick();
        n_vec++; if (state !== 3'd4 || error_out !== 1'b1) begin
            n_err++; $display("FAIL thr_error: got st%0d e%0b expected st4 e1", state, error_out);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_pause();
        test_simul();
        test_midreset();
        test_error();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
